mcycle_ctrl: RTL and testbench

MCYCLE_CTRL -- requirements
Module: mcycle_ctrl

---
 rtl/mcycle_pkg.sv | 44 ++++
 rtl/mcycle_dec.sv | 78 +++++++
 rtl/mcycle_ctrl.sv | 107 ++++++++++
 tb/tb_mcycle_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcycle_pkg.sv
// Shared constants for the machine-cycle sequencer: chk_i field indices,
// ienb bit indices and the T-state encoding.
package mcycle_pkg;

  localparam int CHK_W  = 17;
  localparam int IENB_W = 7;

  localparam int CHK_GO6   = 0;
  localparam int CHK_DAD   = 1;
  localparam int CHK_HLT   = 2;
  localparam int CHK_DIO   = 3;
  localparam int CHK_GO_LO = 4;
  localparam int CHK_RW_LO = 8;
  localparam int CHK_CD_LO = 12;
  localparam int CHK_CCC   = 16;

  localparam int IE_RRD = 0;
  localparam int IE_RWR = 1;
  localparam int IE_COD = 2;
  localparam int IE_DAT = 3;
  localparam int IE_PC  = 4;
  localparam int IE_PD  = 5;
  localparam int IE_NXT = 6;

  localparam logic [2:0] MC_M1 = 3'd0;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T1   = 4'd1,
    ST_T2   = 4'd2,
    ST_TW   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_HALT = 4'd8
  } state_e;

  // Per-cycle nibble fields (cycgo / cycrw / cyccd), bit k belongs to M(k+2).
  function automatic logic [3:0] nib(input logic [CHK_W-1:0] chk, input int lo);
    return chk[lo +: 4];
  endfunction

endpackage

// File: rtl/mcycle_dec.sv
// Moore output decoder: (state, mcyc, chk_i) -> ienb, ale, rd_, wr_.
// TW repeats the T2 strobes except the one-shot PC_ increment.
module mcycle_dec
  import mcycle_pkg::*;
(
  input  state_e              i_state,
  input  logic [2:0]          i_mcyc,
  input  logic [CHK_W-1:0]    i_chk,
  output logic [IENB_W-1:0]   o_ienb,
  output logic                o_ale,
  output logic                o_rd_n,
  output logic                o_wr_n
);

  logic [1:0] w_k;
  logic       w_m1;
  logic [3:0] w_rw;
  logic [3:0] w_cd;
  logic       w_unused;

  assign w_k  = 2'(i_mcyc - 3'd1);
  assign w_m1 = (i_mcyc == MC_M1);
  assign w_rw = nib(i_chk, CHK_RW_LO);
  assign w_cd = nib(i_chk, CHK_CD_LO);
  assign w_unused = ^{i_chk[CHK_DAD], i_chk[CHK_HLT], i_chk[CHK_DIO],
                      i_chk[CHK_GO_LO+1 +: 3], i_chk[CHK_CCC]};

  always_comb begin
    o_ienb = '0;
    o_ale  = 1'b0;
    o_rd_n = 1'b1;
    o_wr_n = 1'b1;
    // PD_/NXT qualify the whole data cycle, T1 included.
    if (!w_m1 && (i_state inside {ST_T1, ST_T2, ST_TW, ST_T3})) begin
      o_ienb[IE_PD]  = w_cd[w_k];
      o_ienb[IE_NXT] = i_mcyc[0];
    end
    case (i_state)
      ST_T1: o_ale = 1'b1;
      ST_T2, ST_TW: begin
        if (!w_m1 && w_rw[w_k]) begin
          o_wr_n         = 1'b0;
          o_ienb[IE_RRD] = 1'b1;
        end else begin
          o_rd_n        = 1'b0;
          o_ienb[IE_PC] = (i_state == ST_T2) && (w_m1 || !w_cd[w_k]);
        end
      end
      ST_T3: begin
        if (w_m1) begin
          o_rd_n         = 1'b0;
          o_ienb[IE_COD] = 1'b1;
        end else if (w_rw[w_k]) begin
          o_wr_n         = 1'b0;
          o_ienb[IE_RRD] = 1'b1;
        end else begin
          o_rd_n         = 1'b0;
          o_ienb[IE_DAT] = 1'b1;
          o_ienb[IE_RWR] = 1'b1;
        end
      end
      ST_T4: begin
        if (!i_chk[CHK_GO6] && !i_chk[CHK_GO_LO]) begin
          o_ienb[IE_RRD] = 1'b1;
          o_ienb[IE_RWR] = 1'b1;
        end
      end
      ST_T6: begin
        if (!i_chk[CHK_GO_LO]) begin
          o_ienb[IE_RRD] = 1'b1;
          o_ienb[IE_RWR] = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mcycle_ctrl.sv
// Machine-cycle / T-state sequencer (M1 fetch plus up to four data cycles).
// Define MCYCLE_READY_EN to stretch T2 with TW wait states while ready is low.
module mcycle_ctrl
  import mcycle_pkg::*;
(
  input  logic                clk,
  input  logic                rst_,
  input  logic [CHK_W-1:0]    chk_i,
  input  logic                ready,
  output logic [IENB_W-1:0]   ienb,
  output logic                ale,
  output logic                rd_,
  output logic                wr_,
  output logic                hlta,
  output logic [2:0]          mcyc,
  output logic [3:0]          o_dbg_state
);

  state_e     r_state;
  state_e     w_state_nxt;
  logic [2:0] r_mcyc;
  logic [2:0] w_mcyc_nxt;
  logic [3:0] w_go;
  logic       w_m1;
  logic       w_more;
  logic       w_close;

  assign w_go   = nib(chk_i, CHK_GO_LO);
  assign w_m1   = (r_mcyc == MC_M1);
  assign w_more = w_m1 ? w_go[0] : ((r_mcyc < 3'd4) && w_go[r_mcyc[1:0]]);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state <= ST_IDLE;
      r_mcyc  <= MC_M1;
    end else begin
      r_state <= w_state_nxt;
      r_mcyc  <= w_mcyc_nxt;
    end
  end

  // ready handshake: sampled at the end of T2/TW; high lets the access
  // proceed to T3, low holds it in TW. Ignored unless MCYCLE_READY_EN.
  always_comb begin
    w_state_nxt = r_state;
    w_mcyc_nxt  = r_mcyc;
    w_close     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_T1;
        w_mcyc_nxt  = MC_M1;
      end
      ST_T1: w_state_nxt = ST_T2;
`ifdef MCYCLE_READY_EN
      ST_T2, ST_TW: w_state_nxt = ready ? ST_T3 : ST_TW;
`else
      ST_T2, ST_TW: w_state_nxt = ST_T3;
`endif
      ST_T3: begin
        if (w_m1) w_state_nxt = ST_T4;
        else      w_close     = 1'b1;
      end
      ST_T4: begin
        if (chk_i[CHK_GO6]) w_state_nxt = ST_T5;
        else                w_close     = 1'b1;
      end
      ST_T5:   w_state_nxt = ST_T6;
      ST_T6:   w_close     = 1'b1;
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_close) begin
      if (w_more) begin
        w_state_nxt = ST_T1;
        w_mcyc_nxt  = r_mcyc + 3'd1;
      end else if (chk_i[CHK_HLT]) begin
        w_state_nxt = ST_HALT;
        w_mcyc_nxt  = MC_M1;
      end else begin
        w_state_nxt = ST_T1;
        w_mcyc_nxt  = MC_M1;
      end
    end
  end

`ifndef MCYCLE_READY_EN
  logic w_unused_ready;
  assign w_unused_ready = ready;
`endif

  mcycle_dec u_dec (
    .i_state (r_state),
    .i_mcyc  (r_mcyc),
    .i_chk   (chk_i),
    .o_ienb  (ienb),
    .o_ale   (ale),
    .o_rd_n  (rd_),
    .o_wr_n  (wr_)
  );

  always_comb begin
    hlta        = (r_state == ST_HALT);
    mcyc        = r_mcyc;
    o_dbg_state = r_state;
  end

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Directed bench for mcycle_ctrl: per-clock vector tables for whole
// instructions, plus wait-state, halt and asynchronous reset sequences.
module tb_mcycle_ctrl;
  import mcycle_pkg::*;

  localparam int OW = 18;

  typedef struct {
    logic [CHK_W-1:0]  chk;
    logic              rdy;
    state_e            st;
    logic [2:0]        mc;
    logic [IENB_W-1:0] ie;
    logic              ale;
    logic              rd;
    logic              wr;
  } vec_t;

  localparam logic [CHK_W-1:0] C_NOP = 17'h00000;
  localparam logic [CHK_W-1:0] C_MVI = 17'h00010;
  localparam logic [CHK_W-1:0] C_MOV = 17'h01110;
  localparam logic [CHK_W-1:0] C_INX = 17'h00001;
  localparam logic [CHK_W-1:0] C_LNG = 17'h034F0;
  localparam logic [CHK_W-1:0] C_HLT = 17'h00014;

  logic              clk   = 1'b0;
  logic              rst_  = 1'b1;
  logic [CHK_W-1:0]  chk_i = '0;
  logic              ready = 1'b1;
  logic [IENB_W-1:0] ienb;
  logic              ale, rd_, wr_, hlta;
  logic [2:0]        mcyc;
  logic [3:0]        dbg_state;
  logic [OW-1:0]     w_obs;

  vec_t          tbl[$];
  logic [OW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int tw_seen = 0;
  int pc_seen = 0;

  mcycle_ctrl dut (
    .clk         (clk),
    .rst_        (rst_),
    .chk_i       (chk_i),
    .ready       (ready),
    .ienb        (ienb),
    .ale         (ale),
    .rd_         (rd_),
    .wr_         (wr_),
    .hlta        (hlta),
    .mcyc        (mcyc),
    .o_dbg_state (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  assign w_obs = {dbg_state, mcyc, ienb, ale, rd_, wr_, hlta};

  function automatic logic [OW-1:0] pack(input state_e s, input logic [2:0] m,
                                         input logic [IENB_W-1:0] ie, input logic a,
                                         input logic r, input logic w, input logic h);
    logic [3:0] sv;
    sv = s;
    return {sv, m, ie, a, r, w, h};
  endfunction

  function automatic vec_t v(input logic [CHK_W-1:0] c, input logic rdy, input state_e s,
                             input logic [2:0] m, input logic [IENB_W-1:0] ie,
                             input logic a, input logic r, input logic w);
    vec_t x;
    x.chk = c; x.rdy = rdy; x.st = s; x.mc = m; x.ie = ie; x.ale = a; x.rd = r; x.wr = w;
    return x;
  endfunction

  // scoreboard
  task automatic score(input string nm, input logic [OW-1:0] act);
    logic [OW-1:0] exp;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got %h, no expected value queued", nm, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
    end
  endtask

  // drivers
  task automatic do_reset(input string nm);
    rst_  = 1'b0;
    chk_i = '0;
    ready = 1'b1;
    #1;
    exp_q.push_back(pack(ST_IDLE, 3'd0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b0));
    score({nm, "_async"}, w_obs);
    repeat (2) @(negedge clk);
    exp_q.push_back(pack(ST_IDLE, 3'd0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b0));
    score({nm, "_held"}, w_obs);
    rst_ = 1'b1;
  endtask

  task automatic add_fetch(input logic [CHK_W-1:0] c);
    tbl.push_back(v(c, 1'b1, ST_T1, 3'd0, 7'h00, 1'b1, 1'b1, 1'b1));
    tbl.push_back(v(c, 1'b1, ST_T2, 3'd0, 7'h10, 1'b0, 1'b0, 1'b1));
    tbl.push_back(v(c, 1'b1, ST_T3, 3'd0, 7'h04, 1'b0, 1'b0, 1'b1));
  endtask

  // One record per clock: inputs held for that state, outputs checked in it.
  task automatic run_table(input string tag);
    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      chk_i = tbl[i].chk;
      ready = tbl[i].rdy;
      #1;
      exp_q.push_back(pack(tbl[i].st, tbl[i].mc, tbl[i].ie, tbl[i].ale,
                           tbl[i].rd, tbl[i].wr, 1'b0));
      if (dbg_state == ST_TW) tw_seen++;
      if (ienb[IE_PC]) pc_seen++;
      score($sformatf("%s[%0d]", tag, i), w_obs);
    end
    tbl.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset("rst0");

    // NOP
    add_fetch(C_NOP);
    tbl.push_back(v(C_NOP, 1'b1, ST_T4, 3'd0, 7'h03, 1'b0, 1'b1, 1'b1));
    // MVI B
    add_fetch(C_MVI);
    tbl.push_back(v(C_MVI, 1'b1, ST_T4, 3'd0, 7'h00, 1'b0, 1'b1, 1'b1));
    tbl.push_back(v(C_MVI, 1'b1, ST_T1, 3'd1, 7'h40, 1'b1, 1'b1, 1'b1));
    tbl.push_back(v(C_MVI, 1'b1, ST_T2, 3'd1, 7'h50, 1'b0, 1'b0, 1'b1));
    tbl.push_back(v(C_MVI, 1'b1, ST_T3, 3'd1, 7'h4A, 1'b0, 1'b0, 1'b1));
    // MOV M,A
    add_fetch(C_MOV);
    tbl.push_back(v(C_MOV, 1'b1, ST_T4, 3'd0, 7'h00, 1'b0, 1'b1, 1'b1));
    tbl.push_back(v(C_MOV, 1'b1, ST_T1, 3'd1, 7'h60, 1'b1, 1'b1, 1'b1));
    tbl.push_back(v(C_MOV, 1'b1, ST_T2, 3'd1, 7'h61, 1'b0, 1'b1, 1'b0));
    tbl.push_back(v(C_MOV, 1'b1, ST_T3, 3'd1, 7'h61, 1'b0, 1'b1, 1'b0));
    // INX (GO6)
    add_fetch(C_INX);
    tbl.push_back(v(C_INX, 1'b1, ST_T4, 3'd0, 7'h00, 1'b0, 1'b1, 1'b1));
    tbl.push_back(v(C_INX, 1'b1, ST_T5, 3'd0, 7'h00, 1'b0, 1'b1, 1'b1));
    tbl.push_back(v(C_INX, 1'b1, ST_T6, 3'd0, 7'h03, 1'b0, 1'b1, 1'b1));
    // five machine cycles, M4 a write, M2/M3 with PD_ set
    add_fetch(C_LNG);
    tbl.push_back(v(C_LNG, 1'b1, ST_T4, 3'd0, 7'h00, 1'b0, 1'b1, 1'b1));
    tbl.push_back(v(C_LNG, 1'b1, ST_T1, 3'd1, 7'h60, 1'b1, 1'b1, 1'b1));
    tbl.push_back(v(C_LNG, 1'b1, ST_T2, 3'd1, 7'h60, 1'b0, 1'b0, 1'b1));
    tbl.push_back(v(C_LNG, 1'b1, ST_T3, 3'd1, 7'h6A, 1'b0, 1'b0, 1'b1));
    tbl.push_back(v(C_LNG, 1'b1, ST_T1, 3'd2, 7'h20, 1'b1, 1'b1, 1'b1));
    tbl.push_back(v(C_LNG, 1'b1, ST_T2, 3'd2, 7'h20, 1'b0, 1'b0, 1'b1));
    tbl.push_back(v(C_LNG, 1'b1, ST_T3, 3'd2, 7'h2A, 1'b0, 1'b0, 1'b1));
    tbl.push_back(v(C_LNG, 1'b1, ST_T1, 3'd3, 7'h40, 1'b1, 1'b1, 1'b1));
    tbl.push_back(v(C_LNG, 1'b1, ST_T2, 3'd3, 7'h41, 1'b0, 1'b1, 1'b0));
    tbl.push_back(v(C_LNG, 1'b1, ST_T3, 3'd3, 7'h41, 1'b0, 1'b1, 1'b0));
    tbl.push_back(v(C_LNG, 1'b1, ST_T1, 3'd4, 7'h00, 1'b1, 1'b1, 1'b1));
    tbl.push_back(v(C_LNG, 1'b1, ST_T2, 3'd4, 7'h10, 1'b0, 1'b0, 1'b1));
    tbl.push_back(v(C_LNG, 1'b1, ST_T3, 3'd4, 7'h0A, 1'b0, 1'b0, 1'b1));
    // NOP with garbage on chk_i during T1..T3 (must be ignored)
    tbl.push_back(v(17'h1FFFF, 1'b1, ST_T1, 3'd0, 7'h00, 1'b1, 1'b1, 1'b1));
    tbl.push_back(v(17'h15A5A, 1'b1, ST_T2, 3'd0, 7'h10, 1'b0, 1'b0, 1'b1));
    tbl.push_back(v(17'h0FFFF, 1'b1, ST_T3, 3'd0, 7'h04, 1'b0, 1'b0, 1'b1));
    tbl.push_back(v(C_NOP,     1'b1, ST_T4, 3'd0, 7'h03, 1'b0, 1'b1, 1'b1));
    tbl.push_back(v(C_NOP,     1'b1, ST_T1, 3'd0, 7'h00, 1'b1, 1'b1, 1'b1));
    run_table("main");

    // ready held low for 3 clocks starting in M1 T2
    do_reset("rst_rdy");
    tw_seen = 0;
    pc_seen = 0;
    tbl.push_back(v(C_NOP, 1'b1, ST_T1, 3'd0, 7'h00, 1'b1, 1'b1, 1'b1));
    tbl.push_back(v(C_NOP, 1'b0, ST_T2, 3'd0, 7'h10, 1'b0, 1'b0, 1'b1));
`ifdef MCYCLE_READY_EN
    tbl.push_back(v(C_NOP, 1'b0, ST_TW, 3'd0, 7'h00, 1'b0, 1'b0, 1'b1));
    tbl.push_back(v(C_NOP, 1'b0, ST_TW, 3'd0, 7'h00, 1'b0, 1'b0, 1'b1));
    tbl.push_back(v(C_NOP, 1'b1, ST_TW, 3'd0, 7'h00, 1'b0, 1'b0, 1'b1));
    tbl.push_back(v(C_NOP, 1'b1, ST_T3, 3'd0, 7'h04, 1'b0, 1'b0, 1'b1));
    tbl.push_back(v(C_NOP, 1'b1, ST_T4, 3'd0, 7'h03, 1'b0, 1'b1, 1'b1));
`else
    tbl.push_back(v(C_NOP, 1'b0, ST_T3, 3'd0, 7'h04, 1'b0, 1'b0, 1'b1));
    tbl.push_back(v(C_NOP, 1'b0, ST_T4, 3'd0, 7'h03, 1'b0, 1'b1, 1'b1));
    tbl.push_back(v(C_NOP, 1'b1, ST_T1, 3'd0, 7'h00, 1'b1, 1'b1, 1'b1));
    tbl.push_back(v(C_NOP, 1'b1, ST_T2, 3'd0, 7'h10, 1'b0, 1'b0, 1'b1));
    tbl.push_back(v(C_NOP, 1'b1, ST_T3, 3'd0, 7'h04, 1'b0, 1'b0, 1'b1));
`endif
    run_table("rdy");
`ifdef MCYCLE_READY_EN
    exp_q.push_back(OW'(3));
    score("tw_count", OW'(tw_seen));
    exp_q.push_back(OW'(1));
    score("pc_pulses", OW'(pc_seen));
`else
    exp_q.push_back(OW'(0));
    score("tw_count", OW'(tw_seen));
    exp_q.push_back(OW'(2));
    score("pc_pulses", OW'(pc_seen));
`endif

    // HLT after M2, then 20 clocks of halt with chk_i wiggling
    do_reset("rst_hlt");
    add_fetch(C_HLT);
    tbl.push_back(v(C_HLT, 1'b1, ST_T4, 3'd0, 7'h00, 1'b0, 1'b1, 1'b1));
    tbl.push_back(v(C_HLT, 1'b1, ST_T1, 3'd1, 7'h40, 1'b1, 1'b1, 1'b1));
    tbl.push_back(v(C_HLT, 1'b1, ST_T2, 3'd1, 7'h50, 1'b0, 1'b0, 1'b1));
    tbl.push_back(v(C_HLT, 1'b1, ST_T3, 3'd1, 7'h4A, 1'b0, 1'b0, 1'b1));
    run_table("hlt");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk_i = 17'($urandom_range(0, 131071));
      ready = 1'($urandom_range(0, 1));
      #1;
      exp_q.push_back(pack(ST_HALT, 3'd0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b1));
      score($sformatf("halt[%0d]", i), {w_obs[17:14], 3'b000, w_obs[10:0]});
    end

    // reset asserted between clock edges while halted
    #1;
    rst_ = 1'b0;
    #1;
    exp_q.push_back(pack(ST_IDLE, 3'd0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b0));
    score("rst_in_halt", w_obs);
    @(negedge clk);
    rst_  = 1'b1;
    ready = 1'b1;
    chk_i = C_HLT;

    // restart, then reset mid-M2 T2 while rd_ is low
    add_fetch(C_HLT);
    tbl.push_back(v(C_HLT, 1'b1, ST_T4, 3'd0, 7'h00, 1'b0, 1'b1, 1'b1));
    tbl.push_back(v(C_HLT, 1'b1, ST_T1, 3'd1, 7'h40, 1'b1, 1'b1, 1'b1));
    tbl.push_back(v(C_HLT, 1'b1, ST_T2, 3'd1, 7'h50, 1'b0, 1'b0, 1'b1));
    run_table("hlt2");
    #1;
    rst_ = 1'b0;
    #1;
    exp_q.push_back(pack(ST_IDLE, 3'd0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b0));
    score("rst_mid_m2", w_obs);
    @(posedge clk);
    #1;
    exp_q.push_back(pack(ST_IDLE, 3'd0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b0));
    score("rst_held_edge", w_obs);
    @(negedge clk);
    rst_ = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(pack(ST_T1, 3'd0, 7'h00, 1'b1, 1'b1, 1'b1, 1'b0));
    score("restart_t1", w_obs);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
